data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_array.sv | 33 +++
 rtl/data_mem_responder.sv | 136 +++++++++++++
 tb/tb_data_mem_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Optional bounds checking in data_mem_responder is enabled by DMEM_BOUNDS_CHECK_EN.
package dmem_pkg;

  localparam int DATA_W      = 32;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // A latency of 1 still needs a one-bit counter register.
  function automatic int cnt_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM: one read or one write per rising edge.
// The read register only changes on a read, so it holds between accesses.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Storage and read register; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_r[addr] <= wdata;
      end else begin
        rdata_r <= mem_r[addr];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// ME-stage data memory responder: accepts one request, answers LATENCY edges later.
// Define DMEM_BOUNDS_CHECK_EN to fault requests with req_addr >= DEPTH instead of wrapping.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = cnt_width(LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic              we_r;
  logic [DATA_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              rsp_valid_r;
  logic              rsp_err_r;
  logic              rsp_zero_r;
  logic              busy_r;
  logic              ready_r;

  logic              accept_s;
  logic              access_s;
  logic              oob_s;
  logic [DATA_W-1:0] ram_rdata_s;

  assign accept_s = req_valid & ready_r;
  assign access_s = (state_r == WAIT) && (cnt_r == {CW{1'b0}});

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob_s = |addr_r[DATA_W-1:AW];
`else
  logic unused_addr_hi_s;
  assign unused_addr_hi_s = ^addr_r[DATA_W-1:AW];
  assign oob_s            = 1'b0;
`endif

  // Request FSM, latency counter and registered handshake/response flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      we_r        <= 1'b0;
      addr_r      <= {DATA_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_zero_r  <= 1'b1;
      busy_r      <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            we_r    <= req_we;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            cnt_r   <= CNT_LOAD;
            state_r <= WAIT;
            busy_r  <= 1'b1;
            ready_r <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= oob_s;
            rsp_zero_r  <= we_r | oob_s;
            busy_r      <= 1'b0;
            ready_r     <= 1'b1;
          end
        end
        RESP: begin
          rsp_valid_r <= 1'b0;
          // Accepting here gives back-to-back requests without a bubble.
          if (accept_s) begin
            we_r    <= req_we;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            cnt_r   <= CNT_LOAD;
            state_r <= WAIT;
            busy_r  <= 1'b1;
            ready_r <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= {CW{1'b0}};
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          ready_r     <= 1'b1;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dmem_array (
    .clk   (clk),
    .en    (access_s & ~oob_s),
    .we    (we_r),
    .addr  (addr_r[AW-1:0]),
    .wdata (wdata_r),
    .rdata (ram_rdata_s)
  );

  assign req_ready = ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  // Stores and faults answer zero; otherwise the RAM read register is the load data.
  assign rsp_rdata = rsp_zero_r ? {DATA_W{1'b0}} : ram_rdata_s;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance A (DEPTH=256, LATENCY=2) and instance B (DEPTH=256, LATENCY=1).
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req_valid, req_we, req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];

  int checks   = 0;
  int failures = 0;

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  data_mem_responder #(.DEPTH(256), .LATENCY(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
  );

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic        OOB_ERR  = 1'b1;
  localparam logic [31:0] ADDR0    = 32'hA5A5_A5A5;
  localparam logic [31:0] OOB_LOAD = 32'h0000_0000;
`else
  localparam logic        OOB_ERR  = 1'b0;
  localparam logic [31:0] ADDR0    = 32'h0BAD_F00D;
  localparam logic [31:0] OOB_LOAD = 32'h0BAD_F00D;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One isolated transaction on instance d, checking handshake, timing and response.
  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic exp_err, input string tag);
    int lat;
    int n;
    lat = (d == 0) ? 2 : 1;
    @(negedge clk);
    check_b({tag, " ready_idle"}, req_ready[d], 1'b1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    @(negedge clk);
    req_valid[d] = 1'b0;
    n = 1;
    while (rsp_valid[d] !== 1'b1 && n < 20) begin
      check_b({tag, " busy_wait"}, busy[d], 1'b1);
      check_b({tag, " ready_wait"}, req_ready[d], 1'b0);
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat + 1));
    check({tag, " rdata"}, rsp_rdata[d], exp_rdata);
    check_b({tag, " err"}, rsp_err[d], exp_err);
    check_b({tag, " busy_resp"}, busy[d], 1'b0);
    @(negedge clk);
    check_b({tag, " strobe_drop"}, rsp_valid[d], 1'b0);
    check({tag, " rdata_hold"}, rsp_rdata[d], exp_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'd5,   32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'd5,   32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'd3,   32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'd3,   32'h0000_0000, 32'h1234_5678, 1'b0};
    vecs[4]  = '{1'b1, 32'd0,   32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b1, 32'd256, 32'h0BAD_F00D, 32'h0000_0000, OOB_ERR};
    vecs[6]  = '{1'b0, 32'd0,   32'h0000_0000, ADDR0,         1'b0};
    vecs[7]  = '{1'b0, 32'd256, 32'h0000_0000, OOB_LOAD,      OOB_ERR};
    vecs[8]  = '{1'b1, 32'd7,   32'h0000_0011, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 32'd7,   32'h0000_0000, 32'h0000_0011, 1'b0};
    vecs[10] = '{1'b1, 32'd255, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, 32'd255, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_we    = 2'b00;
    for (int d = 0; d < 2; d++) begin
      req_addr[d]  = 32'd0;
      req_wdata[d] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_b($sformatf("reset%0d rsp_valid", d), rsp_valid[d], 1'b0);
      check($sformatf("reset%0d rdata", d), rsp_rdata[d], 32'd0);
      check_b($sformatf("reset%0d err", d), rsp_err[d], 1'b0);
      check_b($sformatf("reset%0d busy", d), busy[d], 1'b0);
      check_b($sformatf("reset%0d ready", d), req_ready[d], 1'b1);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
          vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // LATENCY=1: back-to-back loads, second accepted in the RESP cycle.
    txn(1, 1'b1, 32'd1, 32'h1111_0001, 32'd0, 1'b0, "b_pre1");
    txn(1, 1'b1, 32'd2, 32'h2222_0002, 32'd0, 1'b0, "b_pre2");
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'd1;
    @(negedge clk);
    check_b("b2b wait1 ready", req_ready[1], 1'b0);
    check_b("b2b wait1 busy", busy[1], 1'b1);
    check_b("b2b wait1 rsp_valid", rsp_valid[1], 1'b0);
    req_addr[1] = 32'd2;
    @(negedge clk);
    check_b("b2b rsp1 valid", rsp_valid[1], 1'b1);
    check("b2b rsp1 rdata", rsp_rdata[1], 32'h1111_0001);
    check_b("b2b rsp1 ready", req_ready[1], 1'b1);
    @(negedge clk);
    check_b("b2b wait2 rsp_valid", rsp_valid[1], 1'b0);
    check_b("b2b wait2 ready", req_ready[1], 1'b0);
    check_b("b2b wait2 busy", busy[1], 1'b1);
    req_valid[1] = 1'b0;
    @(negedge clk);
    check_b("b2b rsp2 valid", rsp_valid[1], 1'b1);
    check("b2b rsp2 rdata", rsp_rdata[1], 32'h2222_0002);
    @(negedge clk);
    check_b("b2b idle valid", rsp_valid[1], 1'b0);

    // LATENCY=2: store to addr 3, load held high while busy, accepted at the RESP edge.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'd3; req_wdata[0] = 32'hCAFE_F00D;
    @(negedge clk);
    check_b("hold c0 busy", busy[0], 1'b1);
    check_b("hold c0 ready", req_ready[0], 1'b0);
    req_we[0] = 1'b0;
    @(negedge clk);
    check_b("hold c1 busy", busy[0], 1'b1);
    check_b("hold c1 rsp_valid", rsp_valid[0], 1'b0);
    @(negedge clk);
    check_b("hold st rsp_valid", rsp_valid[0], 1'b1);
    check("hold st rdata", rsp_rdata[0], 32'd0);
    check_b("hold st ready", req_ready[0], 1'b1);
    @(negedge clk);
    check_b("hold ld acc rsp_valid", rsp_valid[0], 1'b0);
    check_b("hold ld acc busy", busy[0], 1'b1);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check_b("hold ld c1 rsp_valid", rsp_valid[0], 1'b0);
    check_b("hold ld c1 busy", busy[0], 1'b1);
    @(negedge clk);
    check_b("hold ld rsp_valid", rsp_valid[0], 1'b1);
    check("hold ld rdata", rsp_rdata[0], 32'hCAFE_F00D);
    @(negedge clk);
    check_b("hold after rsp_valid", rsp_valid[0], 1'b0);
    check_b("hold after busy", busy[0], 1'b0);

    // Reset in WAIT of a store to addr 7 must drop it entirely.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'd7; req_wdata[0] = 32'h0000_0099;
    @(negedge clk);
    check_b("rstw wait busy", busy[0], 1'b1);
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_b("rstw busy", busy[0], 1'b0);
    check_b("rstw ready", req_ready[0], 1'b1);
    check_b("rstw rsp_valid", rsp_valid[0], 1'b0);
    check("rstw rdata", rsp_rdata[0], 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_b($sformatf("rstw quiet%0d", c), rsp_valid[0], 1'b0);
    end
    txn(0, 1'b0, 32'd7, 32'd0, 32'h0000_0011, 1'b0, "rstw load7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
